// File: rtl/mesh_out_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// Mesh -- shared types for the 2D mesh router.
//
// Contents:
//   NUM_PORTS  number of router ports (Local, North, East, South, West)
//   Dir        port / direction encoding, also used as the input index
//   Address    64-bit destination address carrying the x/y tile coordinates
//   Packet     128-bit flit; read and write views share the address field,
//              so the destination always sits in the top 64 bits
//   route_xy   dimension-ordered (X first, then Y) routing decision
// ---------------------------------------------------------------------------
package Mesh;

   localparam int NUM_PORTS = 5;

   typedef enum logic [2:0] {
      DIR_LOCAL = 3'd0,
      DIR_NORTH = 3'd1,
      DIR_EAST  = 3'd2,
      DIR_SOUTH = 3'd3,
      DIR_WEST  = 3'd4
   } Dir;

   typedef logic [14:0] Coord;

   // x and y occupy the low 30 bits of the address; the remaining bits are
   // the byte offset inside the destination tile and play no part in routing.
   typedef struct packed {
      logic [33:0] offset;
      Coord        y;
      Coord        x;
   } Address;

   typedef struct packed {
      Address      address;
      logic [31:0] tag;
      logic [31:0] len;
   } ReadReq;

   typedef struct packed {
      Address      address;
      logic [63:0] data;
   } WriteReq;

   // Both views start with the address, so either member can be used to
   // read the destination without looking at a type tag.
   typedef union packed {
      ReadReq  read;
      WriteReq write;
   } Packet;

   // XY routing with unsigned 15-bit compares: resolve x first, then y,
   // and deliver locally once both match.
   function automatic Dir route_xy(Address dst, logic [14:0] x, logic [14:0] y);
      Dir d;
      if (dst.x > x)
         d = DIR_EAST;
      else if (dst.x < x)
         d = DIR_WEST;
      else if (dst.y > y)
         d = DIR_NORTH;
      else if (dst.y < y)
         d = DIR_SOUTH;
      else
         d = DIR_LOCAL;
      return d;
   endfunction

endpackage

// File: rtl/mesh_out_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter -- round-robin arbiter with an internal priority pointer.
//
// The grant goes to the first requester found scanning rr, rr+1, ... modulo
// N. The pointer moves to (adv_idx + 1) mod N only when the owner reports
// that the grant was actually consumed, so a grant that is not taken (for
// example under backpressure) keeps its priority.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset; clears the pointer to 0
//   req        per-requester request
//   advance    a transfer happened this cycle
//   adv_idx    index that was served (pointer moves just past it)
//   grant      one-hot grant (all zero when nothing is requested)
//   grant_idx  binary index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int N  = 5,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   input  logic [IW-1:0] adv_idx,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   // One spare bit so rr + offset cannot overflow before the wrap.
   localparam logic [IW:0]   N_W   = (IW+1)'(N);
   localparam logic [IW-1:0] LAST  = IW'(N - 1);

   logic [IW-1:0] rr;
   logic [IW:0]   scan;
   logic          found;

   // NOTE: every variable written here gets a default before any branch,
   // otherwise a path that skips the assignment would infer a latch.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      scan      = '0;
      for (int off = 0; off < N; off++) begin
         scan = {1'b0, rr} + (IW+1)'(off);
         if (scan >= N_W)
            scan = scan - N_W;
         if (!found && req[scan[IW-1:0]]) begin
            found     = 1'b1;
            grant_idx = scan[IW-1:0];
         end
      end
      if (found)
         grant[grant_idx] = 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples its inputs from the same edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n)
         rr <= '0;
      else if (advance)
         rr <= (adv_idx == LAST) ? '0 : adv_idx + 1'b1;
   end

endmodule

// File: rtl/mesh_out_arbiter.sv
// ---------------------------------------------------------------------------
// mesh_out_arbiter -- scheduler for one output direction of a mesh router.
//
// Every input packet is routed with XY routing; inputs whose route matches
// OUT_DIR compete in a round-robin arbiter, and the winner is moved into a
// single-entry output register. A router instantiates one of these per
// output direction, all fed from the same input buses.
//
// Parameters:
//   NUM_IN   number of input ports, indexed by the Dir encoding
//   OUT_DIR  direction driven by this instance
//   X_COORD  this router's x coordinate
//   Y_COORD  this router's y coordinate
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset
//   in_valid    per-input packet valid
//   in_packet   per-input packet
//   in_ready    per-input accept, at most one bit set (combinational)
//   out_valid   output register holds a packet
//   out_ready   downstream accepts the output packet
//   out_packet  registered packet
//   out_src     input that supplied out_packet
// ---------------------------------------------------------------------------
module mesh_out_arbiter
   import Mesh::*;
#(
   parameter int          NUM_IN  = NUM_PORTS,
   parameter Dir          OUT_DIR = DIR_EAST,
   parameter logic [14:0] X_COORD = 15'd0,
   parameter logic [14:0] Y_COORD = 15'd0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_IN-1:0]   in_valid,
   input  Packet [NUM_IN-1:0]  in_packet,
   output logic [NUM_IN-1:0]   in_ready,
   output logic                out_valid,
   input  logic                out_ready,
   output Packet               out_packet,
   output Dir                  out_src
);

   localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   logic [NUM_IN-1:0] eligible;
   logic [NUM_IN-1:0] grant;
   logic [IW-1:0]     grant_idx;
   logic              can_load;
   logic              xfer;

   // Route compare per input. The read view is used to pick the address;
   // the write view aliases the same bits.
   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_route
      assign eligible[gi] = in_valid[gi] &&
         (route_xy(in_packet[gi].read.address, X_COORD, Y_COORD) == OUT_DIR);
   end

   rr_arbiter #(
      .N (NUM_IN)
   ) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (eligible),
      .advance   (xfer),
      .adv_idx   (grant_idx),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // The register can take a new packet when it is empty or being drained
   // this same cycle. The grant is masked during reset because out_valid is
   // already 0 then and would otherwise let a request through.
   assign can_load = !out_valid || out_ready;
   assign in_ready = (rst_n && can_load) ? grant : '0;

   // A granted input is always valid, so any in_ready bit is a transfer.
   assign xfer = |in_ready;

   // NOTE: the whole output register is reset, data included, so out_packet
   // reads as zero after reset instead of holding stale traffic.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_packet <= '0;
         out_src    <= DIR_LOCAL;
      end else if (xfer) begin
         out_valid  <= 1'b1;
         out_packet <= in_packet[grant_idx];
         out_src    <= Dir'(3'(grant_idx));
      end else if (out_ready) begin
         // Drain without refill: data and source are left as they were.
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mesh_out_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for mesh_out_arbiter at router (3,5), OUT_DIR = EAST.
// Directed vector table, hand-written multi-cycle sequences, then random
// traffic compared against a cycle-level reference model.
// ---------------------------------------------------------------------------
module tb_mesh_out_arbiter;
   import Mesh::*;

   localparam int          N  = 5;
   localparam logic [14:0] XC = 15'd3;
   localparam logic [14:0] YC = 15'd5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     in_valid;
   Packet [N-1:0]    in_packet;
   logic [N-1:0]     in_ready;
   logic             out_valid;
   logic             out_ready;
   Packet            out_packet;
   Dir               out_src;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mesh_out_arbiter #(
      .NUM_IN  (N),
      .OUT_DIR (DIR_EAST),
      .X_COORD (XC),
      .Y_COORD (YC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_packet  (in_packet),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_packet (out_packet),
      .out_src    (out_src)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Advance to one time unit past the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic Packet mk_pkt(input int x, input int y, input logic [63:0] tag);
      Packet p;
      p = '0;
      p.write.address.x      = 15'(x);
      p.write.address.y      = 15'(y);
      p.write.address.offset = tag[33:0];
      p.write.data           = tag;
      return p;
   endfunction

   task automatic drive_all(input int x, input int y, input int seed);
      for (int i = 0; i < N; i++)
         in_packet[i] = mk_pkt(x, y, {32'(seed), 32'(i)});
   endtask

   // ---------------- reference model ----------------
   // Direction numbers: 0 local, 1 north, 2 east, 3 south, 4 west.
   function automatic int model_route(input int x, input int y);
      if (x != 3) return (x > 3) ? 2 : 4;
      if (y != 5) return (y > 5) ? 1 : 3;
      return 0;
   endfunction

   int    dx [N];
   int    dy [N];
   int    m_rr;
   bit    m_valid;
   Packet m_pkt;
   int    m_src;

   function automatic int model_pick();
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_rr + k) % N;
         if (in_valid[i] && model_route(dx[i], dy[i]) == 2)
            return i;
      end
      return -1;
   endfunction

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = '0;
      cyc();
      rst_n    = 1'b1;
      m_rr = 0; m_valid = 0; m_pkt = '0; m_src = 0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [N-1:0] v;
      int           x;
      int           y;
      logic         ordy;
      logic [N-1:0] exp_rdy;
      logic         exp_ov;
      int           exp_src;
   } vec_t;

   vec_t  tbl [13];
   Packet exp_pkt;
   Packet hold_pkt;

   initial begin
      // Applied back to back from reset (rr = 0, register empty).
      tbl[0]  = '{5'b00010, 7, 0, 1'b1, 5'b00010, 1'b1, 1};  // north input, goes east
      tbl[1]  = '{5'b00001, 2, 5, 1'b1, 5'b00000, 1'b0, 1};  // routes west: drain only
      tbl[2]  = '{5'b00001, 3, 9, 1'b1, 5'b00000, 1'b0, 1};  // routes north
      tbl[3]  = '{5'b00001, 3, 5, 1'b1, 5'b00000, 1'b0, 1};  // routes local
      tbl[4]  = '{5'b11111, 10, 10, 1'b1, 5'b00100, 1'b1, 2}; // rr = 2 after input 1
      tbl[5]  = '{5'b11111, 10, 10, 1'b1, 5'b01000, 1'b1, 3};
      tbl[6]  = '{5'b11111, 10, 10, 1'b1, 5'b10000, 1'b1, 4};
      tbl[7]  = '{5'b11111, 10, 10, 1'b1, 5'b00001, 1'b1, 0};
      tbl[8]  = '{5'b11111, 10, 10, 1'b1, 5'b00010, 1'b1, 1};
      tbl[9]  = '{5'b11111, 10, 10, 1'b0, 5'b00000, 1'b1, 1}; // full: hold
      tbl[10] = '{5'b00000, 10, 10, 1'b1, 5'b00000, 1'b0, 1}; // drain only
      tbl[11] = '{5'b00100, 0, 0, 1'b1, 5'b00000, 1'b0, 1};   // routes west
      tbl[12] = '{5'b01010, 4, 5, 1'b1, 5'b01000, 1'b1, 3};   // rr still 2

      // ---- reset state, grant masked while rst_n is low ----
      rst_n     = 1'b0;
      out_ready = 1'b1;
      in_valid  = '1;
      drive_all(10, 10, 100);
      cyc();
      check("reset out_valid", out_valid, 0);
      check("reset out_packet", out_packet, 0);
      check("reset out_src", out_src, 0);
      check("reset in_ready masked", in_ready, 0);
      in_valid = '0;
      rst_n    = 1'b1;

      // ---- table ----
      exp_pkt = '0;
      for (int k = 0; k < 13; k++) begin
         in_valid  = tbl[k].v;
         out_ready = tbl[k].ordy;
         drive_all(tbl[k].x, tbl[k].y, k);
         #1;
         check($sformatf("vec%0d in_ready", k), in_ready, tbl[k].exp_rdy);
         for (int i = 0; i < N; i++)
            if (tbl[k].exp_rdy[i]) exp_pkt = in_packet[i];
         cyc();
         check($sformatf("vec%0d out_valid", k), out_valid, tbl[k].exp_ov);
         check($sformatf("vec%0d out_src", k), out_src, tbl[k].exp_src);
         if (tbl[k].exp_ov)
            check($sformatf("vec%0d out_packet", k), out_packet, exp_pkt);
      end

      // ---- round-robin from reset: 0,1,2,3,4,0 ----
      do_reset();
      in_valid  = '1;
      out_ready = 1'b1;
      drive_all(10, 10, 200);
      for (int s = 0; s < 6; s++) begin
         #1;
         check($sformatf("rr%0d in_ready", s), in_ready, 5'b00001 << (s % N));
         cyc();
         check($sformatf("rr%0d out_valid", s), out_valid, 1);
         check($sformatf("rr%0d out_src", s), out_src, s % N);
      end

      // ---- backpressure ----
      do_reset();
      in_valid  = 5'b00001;
      out_ready = 1'b1;
      drive_all(9, 5, 300);
      hold_pkt = in_packet[0];
      #1;
      check("bp load in_ready", in_ready, 5'b00001);
      cyc();
      in_valid  = 5'b01010;
      out_ready = 1'b0;
      drive_all(9, 5, 301);
      for (int s = 0; s < 3; s++) begin
         #1;
         check($sformatf("bp%0d in_ready", s), in_ready, 0);
         cyc();
         check($sformatf("bp%0d out_valid", s), out_valid, 1);
         check($sformatf("bp%0d out_packet", s), out_packet, hold_pkt);
      end
      out_ready = 1'b1;
      #1;
      check("bp release in_ready", in_ready, 5'b00010);
      cyc();
      check("bp release out_src", out_src, 1);
      check("bp release out_packet", out_packet, in_packet[1]);
      check("bp release out_valid", out_valid, 1);

      // ---- reset mid-stream: rr is 2 here, must return to 0 ----
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      check("midrst in_ready", in_ready, 0);
      cyc();
      check("midrst out_valid", out_valid, 0);
      check("midrst out_packet", out_packet, 0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      check("midrst lowest grant", in_ready, 5'b00010);
      cyc();
      check("midrst out_src", out_src, 1);

      // ---- randomized traffic against the model ----
      do_reset();
      for (int c = 0; c < 400; c++) begin
         int g;
         if (c == 200) do_reset();
         for (int i = 0; i < N; i++) begin
            in_valid[i] = 1'($urandom_range(0, 1));
            dx[i] = ($urandom_range(0, 7) == 0) ? 32'h7ff0 : int'($urandom_range(0, 6));
            dy[i] = int'($urandom_range(2, 8));
            in_packet[i] = mk_pkt(dx[i], dy[i], {$urandom, $urandom});
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         g = model_pick();
         if (g >= 0 && (!m_valid || out_ready)) begin
            check("rand in_ready", in_ready, 5'b00001 << g);
            m_pkt   = in_packet[g];
            m_src   = g;
            m_valid = 1;
            m_rr    = (g + 1) % N;
         end else begin
            check("rand in_ready", in_ready, 0);
            if (out_ready) m_valid = 0;
         end
         cyc();
         check("rand out_valid", out_valid, m_valid);
         check("rand out_src", out_src, m_src);
         check("rand out_packet", out_packet, m_pkt);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mesh_out_arbiter.md
# mesh_out_arbiter

Output-port scheduler for one direction of a 2D mesh router. It takes packets from all five router inputs (Local, North, East, South, West) and computes the XY route for each. It grants one eligible input per cycle using round-robin arbitration, and forwards the granted packet through a single-entry output register. A router instantiates five of these, one per output direction, all sharing the same input buses.

## Interface
Parameters:
- `NUM_IN`, 5: number of input ports, indexed by `Mesh::Dir` encoding.
- `OUT_DIR`, `Mesh::DIR_EAST`: direction this instance drives (`Mesh::Dir`).
- `X_COORD`, 0: this router's x coordinate, 15 bits unsigned.
- `Y_COORD`, 0: this router's y coordinate, 15 bits unsigned.

Ports:
- `clk`  in  1  clock; one clock domain; reset is synchronous and active-low.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  NUM_IN  per-input packet valid.
- `in_packet`  in  NUM_IN x 128  per-input `Mesh::Packet`.
- `in_ready`  out  NUM_IN  per-input accept; at most one bit set.
- `out_valid`  out  1  output register holds a packet.
- `out_ready`  in  1  downstream accepts.
- `out_packet`  out  128  registered `Mesh::Packet`.
- `out_src`  out  3  `Mesh::Dir` of the input that supplied `out_packet`.

## Operation
- **Destination extraction:** take the top 64 bits of the packet (`read.address` and `write.address` alias there). No type tag is needed.
- **XY route, unsigned 15-bit compares:**
  - dst.x > X_COORD → EAST; dst.x < X_COORD → WEST.
  - Otherwise dst.y > Y_COORD → NORTH; dst.y < Y_COORD → SOUTH.
  - Otherwise → LOCAL.
- **Eligibility:** input i is eligible when `in_valid[i]` is set and route(i) == OUT_DIR. No U-turn suppression: an input whose index equals OUT_DIR is still eligible.
- **Arbitration:** round-robin pointer `rr` (0..NUM_IN-1). The grant goes to the first eligible index scanning rr, rr+1, … modulo NUM_IN.
- **can_load:** `!out_valid || out_ready`.
- **in_ready:** `in_ready[g] = can_load` for the granted index g; all other bits are 0. in_ready is combinational from in_valid, out_valid and out_ready.
- **Transfer:** happens on `in_valid[g] && in_ready[g]`.
  - `out_packet ← in_packet[g]`, `out_src ← g`, `out_valid ← 1`.
  - `rr ← (g+1) mod NUM_IN`.
- **Drain without refill:** if `out_valid && out_ready` and there is no transfer, `out_valid ← 0`. out_packet and out_src hold their values.
- **No transfer otherwise:** rr is unchanged when no transfer occurs.
- **Upstream protocol:** after raising in_valid, the sender holds in_valid and in_packet stable until accepted. The block keeps no per-input state, so a withdrawn request simply drops out of arbitration.

## Timing
- **Reset** (rst_n low at a clk edge): out_valid=0, out_packet=0, out_src=0, rr=0. in_ready is 0 during reset because out_valid=0 but the grant is masked while !rst_n.
- **Latency:** one cycle. A packet accepted in cycle t appears on out_valid/out_packet in cycle t+1.
- **Throughput:** one packet per cycle while out_ready is held high (simultaneous drain and load).
- **Full:** out_valid=1 and out_ready=0 forces all in_ready to 0; the output register holds.
- **Empty with no eligible inputs:** out_valid stays 0; rr holds.
- **Fairness:** with k persistently eligible inputs, each is granted once per k transfers.
- **Reset mid-operation:** the packet held in the output register is discarded. No partial state survives.

## Structure
- **Package `Mesh` additions:**
  - `typedef enum logic [2:0] Dir` with DIR_LOCAL=0, DIR_NORTH=1, DIR_EAST=2, DIR_SOUTH=3, DIR_WEST=4.
  - `function Dir route_xy(Address dst, logic [14:0] x, logic [14:0] y)`.
  - Constant `NUM_PORTS = 5`.
- **Sub-module `rr_arbiter`:** parameter N. Inputs: req[N], advance, and the granted index to advance from. Outputs: grant one-hot and grant index. It owns the rr register.
- **mesh_out_arbiter itself:** route compare, eligibility mask, and the output register.

## Test plan
Router at (3,5), OUT_DIR=EAST unless noted.
- **Basic route and latency:** reset, then NORTH input valid with dst (7,0), out_ready=1.
  - in_ready[NORTH]=1 in the same cycle.
  - Next cycle: out_valid=1, out_src=1, out_packet equals the input.
- **Route filtering:**
  - dst (2,5) on LOCAL → never granted (routes WEST).
  - dst (3,9) → NORTH, not eligible.
  - dst (3,5) → LOCAL, not eligible.
  - In all three cases in_ready stays 0 and out_valid stays 0.
- **Round-robin:** all five inputs hold dst (10,10), out_ready=1.
  - Grants in order 0,1,2,3,4,0; out_valid high every cycle after the first.
- **Backpressure:** one packet loaded, then out_ready=0 for 3 cycles while inputs 1 and 3 are eligible.
  - in_ready=0 throughout; out_packet is stable.
  - When out_ready rises: the drain and the grant to input 1 happen in the same cycle.
- **Drain only:** out_valid=1, out_ready=1, no eligible inputs → out_valid=0 next cycle; rr unchanged.
- **Reset mid-stream:** rst_n low for one cycle while out_valid=1 and out_ready=0 → out_valid=0, rr=0; the next grant goes to the lowest eligible index.
